// File: rtl/aes_tbox_pkg.sv
// Shared AES lookup definitions: 40-bit T-box entry type, mode encoding,
// elaboration-time forward/inverse entry tables and the row rotation helper.
package aes_tbox_pkg;

    typedef logic [39:0] entry_t;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } engine_state_e;

    localparam int TBL_BITS = 256 * 40;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES expects.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [TBL_BITS-1:0] build_fwd();
        logic [TBL_BITS-1:0] t;
        logic [7:0] s;
        t = '0;
        for (int b = 0; b < 256; b++) begin
            s = sbox_byte(8'(b));
            t[b*40 +: 40] = {s, xtime(s), s, s, xtime(s) ^ s};
        end
        return t;
    endfunction

    // Filled by walking the forward S-box, so entry InvS(b) lands at index b.
    function automatic logic [TBL_BITS-1:0] build_inv();
        logic [TBL_BITS-1:0] t;
        logic [7:0] s;
        logic [7:0] x;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            s = sbox_byte(x);
            t[int'(s)*40 +: 40] = {x, gf_mul(x, 8'h0e), gf_mul(x, 8'h09),
                                   gf_mul(x, 8'h0d), gf_mul(x, 8'h0b)};
        end
        return t;
    endfunction

    localparam logic [TBL_BITS-1:0] FWD_TBOX = build_fwd();
    localparam logic [TBL_BITS-1:0] INV_TBOX = build_inv();

    function automatic entry_t tbox_lookup(input mode_e m, input logic [7:0] b);
        return (m == MODE_INV) ? INV_TBOX[int'(b)*40 +: 40] : FWD_TBOX[int'(b)*40 +: 40];
    endfunction

    function automatic entry_t rot_row(input entry_t e, input logic [1:0] r);
        logic [31:0] w;
        w = e[31:0];
        case (r)
            2'd1:    w = {w[7:0],  w[31:8]};
            2'd2:    w = {w[15:0], w[31:16]};
            2'd3:    w = {w[23:0], w[31:24]};
            default: w = e[31:0];
        endcase
        return {e[39:32], w};
    endfunction

endpackage

// File: rtl/tbox_lane.sv
// One column lookup: four byte rows through the selected table, each entry
// rotated by its row so the column mix can simply XOR the lanes downstream.
module tbox_lane
    import aes_tbox_pkg::*;
(
    input  mode_e        mode,
    input  logic [31:0]  col,
    output logic [159:0] entries
);

    always_comb begin
        entries = '0;
        for (int r = 0; r < 4; r++) begin
            entries[r*40 +: 40] = rot_row(tbox_lookup(mode, col[(3-r)*8 +: 8]), 2'(r));
        end
    end

endmodule

// File: rtl/sbox_tbox_engine.sv
// Latches a 128-bit state and streams its T-box lookups NLANES columns per beat,
// with valid/ready on both sides and back-to-back acceptance on the last beat.
module sbox_tbox_engine
    import aes_tbox_pkg::*;
#(
    parameter int NLANES = 4,
    parameter int NBEATS = 4 / NLANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [127:0]           in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NLANES*160-1:0]  out_words,
    output logic [1:0]             out_col,
    output logic                   out_last
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the source holds its payload stable while valid is high and ready is low.

    localparam logic [1:0] BEAT_MASK = 2'(NBEATS - 1);

    engine_state_e          state_q;
    logic [127:0]           data_q;
    mode_e                  mode_q;
    logic [1:0]             beat_q;

    logic                   take;
    logic                   fire;
    logic [1:0]             beat_next;
    logic [1:0]             beat_sel;
    logic [127:0]           src_data;
    mode_e                  src_mode;
    logic [NLANES*160-1:0]  lane_words;

    assign fire      = out_valid & out_ready;
    assign in_ready  = (state_q == IDLE) | (fire & out_last);
    assign take      = in_valid & in_ready;
    assign beat_next = (beat_q + 2'd1) & BEAT_MASK;

    // An accepted state feeds the lanes directly so its first beat is registered next cycle.
    always_comb begin
        src_data = data_q;
        src_mode = mode_q;
        beat_sel = beat_next;
        if (take) begin
            src_data = in_state;
            src_mode = mode_e'(in_mode);
            beat_sel = 2'd0;
        end
    end

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic [1:0] col_idx;
        assign col_idx = 2'(int'(beat_sel) * NLANES + l);

        tbox_lane u_lane (
            .mode    (src_mode),
            .col     (src_data[int'(col_idx)*32 +: 32]),
            .entries (lane_words[l*160 +: 160])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mode_q    <= MODE_FWD;
            beat_q    <= 2'd0;
            out_valid <= 1'b0;
            out_words <= '0;
            out_col   <= 2'd0;
            out_last  <= 1'b0;
        end else if (take) begin
            state_q   <= RUN;
            data_q    <= in_state;
            mode_q    <= mode_e'(in_mode);
            beat_q    <= 2'd0;
            out_valid <= 1'b1;
            out_words <= lane_words;
            out_col   <= 2'd0;
            out_last  <= (NBEATS == 1);
        end else if (fire) begin
            if (out_last) begin
                state_q   <= IDLE;
                out_valid <= 1'b0;
                beat_q    <= 2'd0;
            end else begin
                beat_q    <= beat_next;
                out_words <= lane_words;
                out_col   <= 2'(int'(beat_next) * NLANES);
                out_last  <= (beat_next == BEAT_MASK);
            end
        end
    end

endmodule
